// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the PC, issues 1-cycle synchronous reads and queues {pc, ins} for decode.
// Issue-to-out_valid latency is 2 cycles; fetch stalls when queued plus in-flight entries reach DEPTH.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              ILEN     = 32,
  parameter int              DEPTH    = 4,
  parameter int              PC_STEP  = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       pc_reset,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic [XLEN-1:0]            ins_address,
  output logic                       ins_read_enable,
  input  logic [ILEN-1:0]            ins_read_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [ILEN-1:0]            out_ins,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(PC_STEP - 1));

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pending_pc;
  logic            r_pending;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;

  logic [XLEN-1:0] r_q_pc  [DEPTH];
  logic [ILEN-1:0] r_q_ins [DEPTH];

  logic [CW:0] w_fill;
  logic        w_issue;
  logic        w_push;
  logic        w_pop;
  logic        w_vld;

  // Slot accounting counts the in-flight read so a returning word always has room.
  assign w_fill  = {1'b0, r_count} + {{CW{1'b0}}, r_pending};
  assign w_issue = !pc_reset && !redirect_valid && (w_fill < (CW+1)'(DEPTH));
  assign w_push  = r_pending && !redirect_valid && !pc_reset;
  assign w_vld   = (r_count != '0);
  assign w_pop   = w_vld && out_ready;

  assign ins_read_enable = w_issue;
  assign ins_address     = r_pc;
  assign out_valid       = w_vld;
  assign out_pc          = w_vld ? r_q_pc[r_rd_ptr]  : '0;
  assign out_ins         = w_vld ? r_q_ins[r_rd_ptr] : '0;
  assign count           = r_count;

  always_ff @(posedge clk or posedge pc_reset) begin
    if (pc_reset) begin
      r_pc         <= RESET_PC;
      r_pending    <= 1'b0;
      r_pending_pc <= '0;
      r_count      <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
    end else if (redirect_valid) begin
      r_pc      <= redirect_pc & ALIGN_MASK;
      r_pending <= 1'b0;
      r_count   <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
    end else begin
      r_pending <= w_issue;
      if (w_issue) begin
        r_pc         <= r_pc + XLEN'(PC_STEP);
        r_pending_pc <= r_pc;
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_wr_ptr]  <= r_pending_pc;
      r_q_ins[r_wr_ptr] <= ins_read_data;
    end
  end

endmodule
